// File: rtl/toy_dmem_resp.sv
// ---------------------------------------------------------------------------
// toy_dmem_resp
//   Single-ported 32-bit data memory with a 1-cycle registered read and an
//   optional posted-write buffer in front of the array.
//
//   Configuration macro: TOY_DMEM_WBUF_EN
//     defined   - writes are posted into a WB_DEPTH-entry FIFO. The FIFO drains
//                 one entry per idle cycle. Reads forward from the youngest
//                 matching entry.
//     undefined - writes go straight into the array. WB_CNT is held at 0 and
//                 WB_EMPTY at 1.
//
//   Parameters
//     AW        word-address width of the array (2^AW words)
//     WB_DEPTH  posted-write buffer entries (2, 4 or 8)
//
//   Ports
//     CLK       clock, rising edge
//     RST       asynchronous active-high reset
//     DREQ      transaction valid this cycle
//     DRW       0 = read, 1 = write (qualified by DREQ)
//     DADDR     word address; only [AW-1:0] is used, upper bits alias
//     DWDATA    write data
//     DRDATA    registered read data, held between reads
//     WB_CNT    posted-write buffer occupancy
//     WB_EMPTY  high when WB_CNT == 0
// ---------------------------------------------------------------------------
module toy_dmem_resp #(
    parameter int AW       = 10,
    parameter int WB_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic [3:0]  WB_CNT,
    output logic        WB_EMPTY
);

    logic [31:0]   mem [0:(1<<AW)-1];

    logic [AW-1:0] addr;
    logic          rd_en;
    logic          wr_en;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   rd_word;

    // Upper address bits alias by design and are intentionally ignored.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^DADDR[29:AW];

    assign addr  = DADDR[AW-1:0];
    assign rd_en = DREQ & ~DRW;
    assign wr_en = DREQ & DRW;

`ifdef TOY_DMEM_WBUF_EN
    localparam int         PW   = $clog2(WB_DEPTH);
    localparam logic [3:0] FULL = 4'(WB_DEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    ptr_t          head, head_next;
    ptr_t          tail, tail_next;
    logic [3:0]    cnt, cnt_next;
    logic          pop;
    logic          fwd_hit;
    logic [31:0]   fwd_data;

    // Walk the valid entries oldest to youngest; a later match overrides an
    // earlier one, so the youngest write to an address is what gets forwarded.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if ((4'(k) < cnt) && (wb_addr[head + PW'(k)] == addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[head + PW'(k)];
            end
        end
    end

    // The oldest entry leaves the buffer either in an idle cycle (normal
    // drain) or when a write meets a full buffer (forced drain). Neither can
    // coincide with a read, so the array stays single-ported.
    always_comb begin
        pop       = (~DREQ & (cnt != 4'd0)) | (wr_en & (cnt == FULL));
        mem_we    = pop;
        mem_waddr = wb_addr[head];
        mem_wdata = wb_data[head];
        head_next = pop   ? head + ptr_t'(1) : head;
        tail_next = wr_en ? tail + ptr_t'(1) : tail;
        cnt_next  = cnt;
        if (wr_en && !pop) begin
            cnt_next = cnt + 4'd1;
        end else if (pop && !wr_en) begin
            cnt_next = cnt - 4'd1;
        end
        rd_word   = fwd_hit ? fwd_data : mem[addr];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= 4'd0;
            WB_EMPTY <= 1'b1;
        end else begin
            head     <= head_next;
            tail     <= tail_next;
            cnt      <= cnt_next;
            WB_EMPTY <= (cnt_next == 4'd0);
        end
    end

    // NOTE: storage arrays carry no reset; validity comes from the reset
    // pointers and count, which keeps these mappable onto RAM.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            wb_addr[tail] <= addr;
            wb_data[tail] <= DWDATA;
        end
    end

    assign WB_CNT = cnt;
`else
    always_comb begin
        mem_we    = wr_en;
        mem_waddr = addr;
        mem_wdata = DWDATA;
        rd_word   = mem[addr];
    end

    assign WB_CNT   = 4'd0;
    assign WB_EMPTY = 1'b1;

    // Buffer depth has no effect without the posted-write buffer.
    logic unused_cfg;
    assign unused_cfg = (WB_DEPTH == 0);
`endif

    // Array write port; transactions are ignored while reset is held.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read data is only updated by a read and holds otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DRDATA <= '0;
        end else if (rd_en) begin
            DRDATA <= rd_word;
        end
    end

endmodule

// File: tb/tb_toy_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_toy_dmem_resp
//   Directed self-checking bench for toy_dmem_resp (AW = 10, WB_DEPTH = 4).
//   Expected buffer occupancy and post-reset array contents follow the
//   TOY_DMEM_WBUF_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_toy_dmem_resp;

`ifdef TOY_DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic [31:0] DRDATA;
    logic [3:0]  WB_CNT;
    logic        WB_EMPTY;

    int checks   = 0;
    int failures = 0;

    toy_dmem_resp #(.AW(10), .WB_DEPTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DREQ     (DREQ),
        .DRW      (DRW),
        .DADDR    (DADDR),
        .DWDATA   (DWDATA),
        .DRDATA   (DRDATA),
        .WB_CNT   (WB_CNT),
        .WB_EMPTY (WB_EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each step drives its inputs for one edge, then waits 1 time unit past
    // that edge so registered outputs are sampled away from the clock.
    task automatic do_write(input logic [29:0] a, input logic [31:0] d);
        DREQ = 1'b1; DRW = 1'b1; DADDR = a; DWDATA = d;
        @(posedge CLK); #1;
    endtask

    task automatic do_read(input logic [29:0] a);
        DREQ = 1'b1; DRW = 1'b0; DADDR = a; DWDATA = '0;
        @(posedge CLK); #1;
    endtask

    task automatic do_idle(input int n);
        DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    logic [31:0] exp_cnt;
    logic [31:0] exp_empty;

    initial begin
        RST = 1'b1; DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_drdata", DRDATA, 32'h0);
        check("reset_wb_cnt", 32'(WB_CNT), 32'd0);
        check("reset_wb_empty", 32'(WB_EMPTY), 32'd1);
        RST = 1'b0;
        do_idle(1);

        // Write then read next cycle.
        do_write(30'h10, 32'hDEADBEEF);
        exp_cnt = WBUF ? 32'd1 : 32'd0;
        check("wr_rd_cnt_after_write", 32'(WB_CNT), exp_cnt);
        exp_empty = WBUF ? 32'd0 : 32'd1;
        check("wr_rd_empty_after_write", 32'(WB_EMPTY), exp_empty);
        do_read(30'h10);
        check("wr_rd_data", DRDATA, 32'hDEADBEEF);
        do_idle(4);
        check("wr_rd_cnt_drained", 32'(WB_CNT), 32'd0);
        check("drdata_hold_idle", DRDATA, 32'hDEADBEEF);

        // Fill the buffer exactly, then drain through idle cycles.
        do_write(30'h1, 32'hA000_0001);
        do_write(30'h2, 32'hA000_0002);
        do_write(30'h3, 32'hA000_0003);
        do_write(30'h4, 32'hA000_0004);
        exp_cnt = WBUF ? 32'd4 : 32'd0;
        check("fill_cnt_full", 32'(WB_CNT), exp_cnt);
        check("fill_empty_full", 32'(WB_EMPTY), exp_empty);
        check("drdata_hold_writes", DRDATA, 32'hDEADBEEF);
        do_idle(4);
        check("fill_cnt_drained", 32'(WB_CNT), 32'd0);
        check("fill_empty_drained", 32'(WB_EMPTY), 32'd1);
        do_read(30'h1); check("fill_rd_1", DRDATA, 32'hA000_0001);
        do_read(30'h2); check("fill_rd_2", DRDATA, 32'hA000_0002);
        do_read(30'h3); check("fill_rd_3", DRDATA, 32'hA000_0003);
        do_read(30'h4); check("fill_rd_4", DRDATA, 32'hA000_0004);

        // Overflow: six writes into a four-entry buffer.
        do_write(30'h20, 32'hB000_0020);
        do_write(30'h21, 32'hB000_0021);
        do_write(30'h22, 32'hB000_0022);
        do_write(30'h23, 32'hB000_0023);
        do_write(30'h24, 32'hB000_0024);
        do_write(30'h25, 32'hB000_0025);
        check("ovf_cnt", 32'(WB_CNT), exp_cnt);
        do_read(30'h20); check("ovf_rd_20", DRDATA, 32'hB000_0020);
        do_read(30'h21); check("ovf_rd_21", DRDATA, 32'hB000_0021);
        do_read(30'h22); check("ovf_rd_22", DRDATA, 32'hB000_0022);
        do_read(30'h23); check("ovf_rd_23", DRDATA, 32'hB000_0023);
        do_read(30'h24); check("ovf_rd_24", DRDATA, 32'hB000_0024);
        do_read(30'h25); check("ovf_rd_25", DRDATA, 32'hB000_0025);
        check("ovf_cnt_after_reads", 32'(WB_CNT), exp_cnt);
        do_idle(4);
        check("ovf_cnt_drained", 32'(WB_CNT), 32'd0);
        do_read(30'h25); check("ovf_rd_25_array", DRDATA, 32'hB000_0025);
        do_read(30'h22); check("ovf_rd_22_array", DRDATA, 32'hB000_0022);

        // Same-address merge: the later write wins.
        do_write(30'h8, 32'h1);
        do_write(30'h8, 32'h2);
        do_read(30'h8);
        check("merge_fwd", DRDATA, 32'h2);
        do_idle(4);
        check("merge_hold", DRDATA, 32'h2);
        do_read(30'h10);
        check("merge_other_addr", DRDATA, 32'hDEADBEEF);
        do_read(30'h8);
        check("merge_array", DRDATA, 32'h2);

        // Aliasing: bit 10 and above are ignored with AW = 10.
        do_write(30'h400, 32'h55);
        do_read(30'h000);
        check("alias_fwd", DRDATA, 32'h55);
        do_idle(4);
        do_read(30'h000);
        check("alias_array", DRDATA, 32'h55);

        // Reset mid-operation discards undrained writes.
        do_write(30'h30, 32'h0000_0300);
        do_write(30'h31, 32'h0000_0301);
        do_write(30'h32, 32'h0000_0302);
        do_idle(4);
        do_write(30'h30, 32'hC000_0030);
        do_write(30'h31, 32'hC000_0031);
        do_write(30'h32, 32'hC000_0032);
        exp_cnt = WBUF ? 32'd3 : 32'd0;
        check("rst_mid_cnt_before", 32'(WB_CNT), exp_cnt);
        // Assert reset between edges while a write is still being offered.
        RST = 1'b1;
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h30; DWDATA = 32'h0BAD_0BAD;
        #1;
        check("rst_mid_drdata", DRDATA, 32'h0);
        check("rst_mid_cnt", 32'(WB_CNT), 32'd0);
        check("rst_mid_empty", 32'(WB_EMPTY), 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        do_idle(2);
        check("rst_mid_cnt_after", 32'(WB_CNT), 32'd0);
        do_read(30'h30);
        check("rst_mid_rd_30", DRDATA, WBUF ? 32'h0000_0300 : 32'hC000_0030);
        do_read(30'h31);
        check("rst_mid_rd_31", DRDATA, WBUF ? 32'h0000_0301 : 32'hC000_0031);
        do_read(30'h32);
        check("rst_mid_rd_32", DRDATA, WBUF ? 32'h0000_0302 : 32'hC000_0032);

        // Write directly followed by read after reset.
        do_write(30'h3FF, 32'h1234_5678);
        do_read(30'h3FF);
        check("post_rst_wr_rd", DRDATA, 32'h1234_5678);
        do_idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/toy_dmem_resp.md
TOY_DMEM_RESP -- requirements
Module: toy_dmem_resp

Interface
REQ-001 SHALL have parameter AW, default 10, word-address width of the storage array (2^AW 32-bit words).
REQ-002 SHALL have parameter WB_DEPTH, default 4, number of posted-write buffer entries; legal values are 2, 4 and 8.
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port DREQ, input, 1 bit; a data transaction is present this cycle.
REQ-006 SHALL have port DRW, input, 1 bit; 0 = read, 1 = write; qualified by DREQ.
REQ-007 SHALL have port DADDR, input, 30 bits, word address; only bits [AW-1:0] are used and upper bits alias.
REQ-008 SHALL have port DWDATA, input, 32 bits, write data; qualified by DREQ&DRW.
REQ-009 SHALL have port DRDATA, output, 32 bits, registered read data.
REQ-010 SHALL have port WB_CNT, output, 4 bits, current posted-write buffer occupancy.
REQ-011 SHALL have port WB_EMPTY, output, 1 bit, high when WB_CNT == 0.

Function
REQ-012 SHALL accept one transaction per cycle with no stall or back-pressure, because the initiator has no wait input.
REQ-013 SHALL, on a read (DREQ=1, DRW=0), present the word at the next rising edge, giving 1-cycle read latency.
REQ-014 SHALL hold DRDATA unchanged in every cycle without a read.
REQ-015 SHALL push each write into the tail of a FIFO posted-write buffer holding {addr[AW-1:0], data}.
REQ-016 SHALL drain at most one oldest buffer entry into the array per cycle, and only in cycles with DREQ=0.
REQ-017 SHALL, on a write arriving with the buffer full, in the same cycle write the oldest entry to the array and push the new write, so WB_CNT stays at WB_DEPTH and no write is lost.
REQ-018 SHALL, on a read, return data from the youngest buffer entry whose address matches the read address; only when no entry matches SHALL it return the array word.
REQ-019 SHALL resolve back-to-back accesses as follows: a write in cycle N followed by a read of the same address in cycle N+1 returns the cycle-N data.
REQ-020 SHALL resolve two buffered writes to the same address by making the later write win, in both forwarding and final array contents.
REQ-021 SHALL keep the array single-ported, so no cycle performs both an array read and an array write, except the forced drain of REQ-017, which only occurs in write cycles.
REQ-022 SHALL update WB_CNT and WB_EMPTY registered, reflecting the state after each edge.
REQ-023 SHALL wrap the buffer head and tail pointers modulo WB_DEPTH.

Reset
REQ-024 SHALL, on RST=1 (asynchronous), clear DRDATA to 0, buffer pointers to 0, WB_CNT to 0 and WB_EMPTY to 1.
REQ-025 SHALL discard buffered, undrained writes when RST asserts mid-operation; the array keeps its previous contents.
REQ-026 SHALL not reset array contents.
REQ-027 SHALL ignore transactions while RST=1; normal operation starts at the first edge after RST deasserts.

Configuration
REQ-028 SHALL, with macro TOY_DMEM_WBUF_EN defined, implement the posted-write buffer and forwarding of REQ-015 through REQ-023.
REQ-029 SHALL, with TOY_DMEM_WBUF_EN undefined, omit the buffer, write each write directly to the array in its own cycle, hold WB_CNT at 0 and WB_EMPTY at 1; read latency and DRDATA behaviour are unchanged.

Verification
REQ-030 SHALL cover write then read: write 0x10 <= 0xDEADBEEF, read 0x10 next cycle -> DRDATA = 0xDEADBEEF one cycle after the read.
REQ-031 SHALL cover write-buffer fill: 4 consecutive writes to 0x1-0x4, no idle cycles -> WB_CNT = 4; 4 idle cycles -> WB_CNT = 0 and the array holds all four values.
REQ-032 SHALL cover overflow: 6 consecutive writes to 0x20-0x25 (WB_DEPTH = 4) -> WB_CNT = 4; reads of 0x20-0x25 return all six values.
REQ-033 SHALL cover same-address merge: write 0x8 <= 0x1, write 0x8 <= 0x2, read 0x8 -> 0x2; after drain, a read of 0x8 -> 0x2.
REQ-034 SHALL cover reset mid-operation: 3 buffered writes, assert RST -> DRDATA = 0, WB_CNT = 0, WB_EMPTY = 1; reads return the pre-write array values.
REQ-035 SHALL cover aliasing: write DADDR = 0x400 (AW = 10) <= 0x55, read 0x000 -> 0x55.
